// File: rtl/mem_access_stage.sv
// Memory-access stage: aligned byte/half/word loads and stores over a req/ready/rvalid
// handshake, pipeline freeze while an access is in flight, and the MEM/WB register.
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ALUOut,
  input  logic [XLEN-1:0] DRAMIn,
  input  logic [1:0]      DRAM_EX_TYPE,
  input  logic            DRAMWE,
  input  logic [1:0]      RWSel,
  input  logic [4:0]      RegWr,
  input  logic            RegWe,
  input  logic            COMPOut,
  input  logic            Unsigned,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      RegWr_o,
  output logic            RegWe_o,
  output logic [XLEN-1:0] WbData_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      off_s;
  logic            is_mem_s, misalign_s, go_s, req_s, stall_s;
  logic            wb_load_s, wb_we_s;
  logic [3:0]      strb_s;
  logic [XLEN-1:0] wdata_s, wb_sel_s, load_buf_r;
  logic [XLEN-1:0] pc_r, wb_data_r;
  logic [4:0]      rd_r;
  logic            we_r, misalign_r;

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] typ,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (typ)
      2'd0:    res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  assign off_s    = ALUOut[1:0];
  assign is_mem_s = DRAMWE | (RWSel == 2'd1);
  assign go_s     = is_mem_s & ~misalign_s;

  // Alignment check and store lane steering
  always_comb begin
    misalign_s = 1'b0;
    strb_s     = 4'b1111;
    wdata_s    = DRAMIn;
    case (DRAM_EX_TYPE)
      2'd0: begin
        strb_s  = 4'b0001 << off_s;
        wdata_s = {4{DRAMIn[7:0]}};
      end
      2'd1: begin
        misalign_s = ALUOut[0];
        strb_s     = 4'b0011 << off_s;
        wdata_s    = {2{DRAMIn[15:0]}};
      end
      default: misalign_s = (off_s != 2'b00);
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_REQ: begin
        if ((state_r == ST_REQ) || go_s) begin
          if (mem_ready) state_nxt_s = DRAMWE ? ST_DONE : ST_WAIT;
          else           state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_WAIT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs; gated by reset so a mid-access reset drops the request at once
  always_comb begin
    req_s   = 1'b0;
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_s   = go_s;
        stall_s = go_s;
      end
      ST_REQ: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
      end
      ST_WAIT: stall_s = 1'b1;
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  assign mem_req   = req_s & rst_n;
  assign stall_o   = stall_s & rst_n;
  assign mem_we    = mem_req & DRAMWE;
  assign mem_addr  = {ALUOut[XLEN-1:2], 2'b00};
  assign mem_wstrb = strb_s;
  assign mem_wdata = wdata_s;

  // Load data buffer, captured only while waiting for the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                load_buf_r <= '0;
    else if ((state_r == ST_WAIT) && mem_rvalid) load_buf_r <= load_extend(mem_rdata, DRAM_EX_TYPE, off_s, Unsigned);
    else                                       load_buf_r <= load_buf_r;
  end

  // Write-back source select and MEM/WB load/enable decisions
  always_comb begin
    case (RWSel)
      2'd0:    wb_sel_s = ALUOut;
      2'd1:    wb_sel_s = load_buf_r;
      2'd2:    wb_sel_s = pc + 32'd4;
      2'd3:    wb_sel_s = {31'd0, COMPOut};
      default: wb_sel_s = ALUOut;
    endcase
    wb_load_s = (state_r == ST_DONE) || ((state_r == ST_IDLE) && !go_s);
    if ((state_r == ST_IDLE) && is_mem_s && misalign_s) wb_we_s = 1'b0;
    else                                                 wb_we_s = RegWe & (RegWr != 5'd0);
  end

  // MEM/WB register; a bubble (write enable low) is loaded while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= '0;
      rd_r       <= 5'd0;
      we_r       <= 1'b0;
      wb_data_r  <= '0;
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= (state_r == ST_IDLE) && is_mem_s && misalign_s;
      if (wb_load_s) begin
        pc_r      <= pc;
        rd_r      <= RegWr;
        we_r      <= wb_we_s;
        wb_data_r <= wb_sel_s;
      end else begin
        we_r <= 1'b0;
      end
    end
  end

  assign pc_o       = pc_r;
  assign RegWr_o    = rd_r;
  assign RegWe_o    = we_r;
  assign WbData_o   = wb_data_r;
  assign misalign_o = misalign_r;

endmodule
